pixel_sensor_top: RTL and testbench

PIXEL_SENSOR_TOP -- requirements
Module: pixel_sensor_top

---
 rtl/pixel_sensor_top_pkg.sv | 22 ++
 rtl/pixel_sensor_top_pixel_array.sv | 34 +++
 rtl/pixel_sensor_top.sv | 146 ++++++++++++++
 tb/tb_pixel_sensor_top.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_sensor_top_pkg.sv
// pixel_sensor_config: shared defaults, scene light model and capture FSM state type.
`timescale 1ps/1ps
package pixel_sensor_config;
    localparam int PIXEL_ARRAY_HEIGHT_DEF = 4;
    localparam int PIXEL_ARRAY_WIDTH_DEF  = 4;
    localparam int PIXEL_BITS_DEF         = 8;
    localparam int OUTPUT_BUS_WIDTH_DEF   = 2;
    localparam int EXPOSE_CYCLES_DEF      = 16;

    typedef enum logic [2:0] {S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DONE} state_e;

    // Light falling on each pixel; the scene source loads it through readScene.
    logic [PIXEL_BITS_DEF-1:0] SCENE [PIXEL_ARRAY_HEIGHT_DEF][PIXEL_ARRAY_WIDTH_DEF];

    // mode 0: dark, mode 1: value 16*row+col, otherwise: saturated
    task automatic readScene(input int mode);
        for (int r = 0; r < PIXEL_ARRAY_HEIGHT_DEF; r++)
            for (int c = 0; c < PIXEL_ARRAY_WIDTH_DEF; c++)
                SCENE[r][c] = (mode == 0) ? '0 :
                              (mode == 1) ? PIXEL_BITS_DEF'(16 * r + c) : '1;
    endtask
endpackage

// File: rtl/pixel_sensor_top_pixel_array.sv
// pixel_array: per-pixel ramp latch; each pixel captures the ramp when it matches its light.
`timescale 1ps/1ps
module pixel_array
    import pixel_sensor_config::*;
#(
    parameter int PIXEL_ARRAY_HEIGHT = PIXEL_ARRAY_HEIGHT_DEF,
    parameter int PIXEL_ARRAY_WIDTH  = PIXEL_ARRAY_WIDTH_DEF,
    parameter int PIXEL_BITS         = PIXEL_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  erase_i,
    input  logic                  convert_i,
    input  logic [PIXEL_BITS-1:0] ramp_i,
    output logic [PIXEL_ARRAY_HEIGHT-1:0][PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] pix_o
);
    for (genvar r = 0; r < PIXEL_ARRAY_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin : g_col
            logic [PIXEL_BITS-1:0] val_q;
            logic                  lat_q;
            always_ff @(posedge clk) begin
                if (!reset || erase_i) begin
                    val_q <= '0;
                    lat_q <= 1'b0;
                end else if (convert_i && !lat_q && ramp_i == PIXEL_BITS'(SCENE[r][c])) begin
                    val_q <= ramp_i;
                    lat_q <= 1'b1;
                end
            end
            // a pixel the ramp never reached reads as full scale
            assign pix_o[r][c] = lat_q ? val_q : '1;
        end
    end
endmodule

// File: rtl/pixel_sensor_top.sv
// pixel_sensor_top: capture FSM on clk, row handshake to a buffer_clk readout with gated strobe.
`timescale 1ps/1ps
module pixel_sensor_top
    import pixel_sensor_config::*;
#(
    parameter int PIXEL_ARRAY_HEIGHT = PIXEL_ARRAY_HEIGHT_DEF,
    parameter int PIXEL_ARRAY_WIDTH  = PIXEL_ARRAY_WIDTH_DEF,
    parameter int PIXEL_BITS         = PIXEL_BITS_DEF,
    parameter int OUTPUT_BUS_WIDTH   = OUTPUT_BUS_WIDTH_DEF,
    parameter int EXPOSE_CYCLES      = EXPOSE_CYCLES_DEF
) (
    input  logic clk,
    input  logic buffer_clk,
    input  logic reset,
    output logic output_clk,
    output logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0] data_out,
    output logic frame_finished
);
    localparam int NW  = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
    localparam int RW  = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int CW  = ((PIXEL_BITS > $clog2(EXPOSE_CYCLES)) ? PIXEL_BITS : $clog2(EXPOSE_CYCLES)) + 1;
    localparam logic [CW-1:0]  EXP_LAST  = CW'(EXPOSE_CYCLES - 1);
    localparam logic [CW-1:0]  RAMP_LAST = CW'((1 << PIXEL_BITS) - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [WCW-1:0] WC_LAST   = WCW'(NW - 1);

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [RW-1:0]     row_q;
    logic              row_req_q, wait_q, ack_seen_q, frame_finished_q;
    logic [1:0]        ack_sync_q;
    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] row_buf_q;
    logic [PIXEL_ARRAY_HEIGHT-1:0][PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] pix;

    logic [1:0]        rst_sync_q, req_sync_q;
    logic              req_seen_q, busy_q, row_ack_q, out_valid_q;
    logic [WCW-1:0]    wc_q;
    logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0] data_out_q;

    pixel_array #(
        .PIXEL_ARRAY_HEIGHT(PIXEL_ARRAY_HEIGHT),
        .PIXEL_ARRAY_WIDTH (PIXEL_ARRAY_WIDTH),
        .PIXEL_BITS        (PIXEL_BITS)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .erase_i  (state_q == S_ERASE),
        .convert_i(state_q == S_CONVERT),
        .ramp_i   (cnt_q[PIXEL_BITS-1:0]),
        .pix_o    (pix)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= S_ERASE;
            cnt_q            <= '0;
            row_q            <= '0;
            row_req_q        <= 1'b0;
            wait_q           <= 1'b0;
            ack_seen_q       <= 1'b0;
            ack_sync_q       <= '0;
            frame_finished_q <= 1'b0;
            row_buf_q        <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[0], row_ack_q};
            case (state_q)
                S_ERASE: begin
                    cnt_q            <= '0;
                    frame_finished_q <= 1'b0;
                    state_q          <= S_EXPOSE;
                end
                S_EXPOSE: begin
                    cnt_q   <= (cnt_q == EXP_LAST) ? '0 : cnt_q + CW'(1);
                    state_q <= (cnt_q == EXP_LAST) ? S_CONVERT : S_EXPOSE;
                end
                S_CONVERT: begin
                    if (cnt_q == RAMP_LAST) begin
                        row_q   <= '0;
                        wait_q  <= 1'b0;
                        state_q <= S_READ;
                    end else
                        cnt_q <= cnt_q + CW'(1);
                end
                // the row buffer is rewritten only after the previous row was acknowledged
                S_READ: begin
                    if (!wait_q) begin
                        row_buf_q <= pix[row_q];
                        row_req_q <= ~row_req_q;
                        wait_q    <= 1'b1;
                    end else if (ack_sync_q[1] != ack_seen_q) begin
                        ack_seen_q <= ack_sync_q[1];
                        wait_q     <= 1'b0;
                        if (row_q == ROW_LAST) begin
                            state_q          <= S_DONE;
                            frame_finished_q <= 1'b1;
                        end else
                            row_q <= row_q + RW'(1);
                    end
                end
                S_DONE: begin
                    frame_finished_q <= 1'b0;
                    state_q          <= S_ERASE;
                end
                default: state_q <= S_ERASE;
            endcase
        end
    end

    // readout side runs on the falling edge so the gated strobe cannot glitch
    always_ff @(negedge buffer_clk) rst_sync_q <= {rst_sync_q[0], reset};

    always_ff @(negedge buffer_clk) begin
        if (!rst_sync_q[1]) begin
            req_sync_q  <= '0;
            req_seen_q  <= 1'b0;
            busy_q      <= 1'b0;
            row_ack_q   <= 1'b0;
            out_valid_q <= 1'b0;
            wc_q        <= '0;
            data_out_q  <= '0;
        end else begin
            req_sync_q <= {req_sync_q[0], row_req_q};
            if (!busy_q) begin
                out_valid_q <= 1'b0;
                if (req_sync_q[1] != req_seen_q) begin
                    req_seen_q <= req_sync_q[1];
                    busy_q     <= 1'b1;
                    wc_q       <= '0;
                end
            end else begin
                out_valid_q <= 1'b1;
                data_out_q  <= row_buf_q[int'(wc_q) * OUTPUT_BUS_WIDTH +: OUTPUT_BUS_WIDTH];
                if (wc_q == WC_LAST) begin
                    busy_q    <= 1'b0;
                    row_ack_q <= ~row_ack_q;
                end else
                    wc_q <= wc_q + WCW'(1);
            end
        end
    end

    assign output_clk     = buffer_clk & out_valid_q;
    assign data_out       = data_out_q;
    assign frame_finished = frame_finished_q;
endmodule

// File: tb/tb_pixel_sensor_top.sv
// tb_pixel_sensor_top: directed scenes, clock ratios, mid-readout reset and back-to-back frames.
`timescale 1ps/1ps
module tb_pixel_sensor_top;
    logic clk = 1'b0, buffer_clk = 1'b0, reset = 1'b0;
    logic output_clk, frame_finished;
    logic [1:0][7:0] data_out;
    int clk_half = 250, bclk_half = 125;
    int tests = 0, fails = 0, ff_rises = 0;
    logic [15:0] words[$];
    int falls[$];

    pixel_sensor_top dut (
        .clk           (clk),
        .buffer_clk    (buffer_clk),
        .reset         (reset),
        .output_clk    (output_clk),
        .data_out      (data_out),
        .frame_finished(frame_finished)
    );

    initial forever #(clk_half) clk = ~clk;
    initial forever #(bclk_half) buffer_clk = ~buffer_clk;

    always @(posedge output_clk) words.push_back(data_out);
    always @(posedge frame_finished) ff_rises++;
    always @(negedge frame_finished) falls.push_back(words.size());

    function automatic logic [7:0] exp_pix(input int mode, input int r, input int c);
        return (mode == 0) ? 8'h00 : (mode == 1) ? 8'(16 * r + c) : 8'hFF;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_rise(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (frame_finished) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s frame_timeout: got no frame_finished, expected one within 4000 clk", name);
        end
        repeat (4) @(posedge buffer_clk);
    endtask

    task automatic check_frame(input string name, input int mode, input int base);
        for (int k = 0; k < 8; k++) begin
            int r = k / 2;
            int w = k % 2;
            logic [15:0] e;
            e = {exp_pix(mode, r, 2 * w + 1), exp_pix(mode, r, 2 * w)};
            tests++;
            if (words.size() <= base + k) begin
                fails++;
                $display("FAIL %s word%0d: got none, expected %h", name, base + k, e);
            end else if (words[base + k] !== e) begin
                fails++;
                $display("FAIL %s word%0d: got %h, expected %h", name, base + k, words[base + k], e);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        tests++;
        if (frame_finished !== 1'b0) begin
            fails++;
            $display("FAIL reset_ff: got %b, expected 0", frame_finished);
        end
        tests++;
        if (data_out !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: got %h, expected 0000", data_out);
        end
        tests++;
        if (words.size() != 0) begin
            fails++;
            $display("FAIL reset_pulses: got %0d, expected 0", words.size());
        end
    endtask

    task automatic test_scene(input string name, input int mode);
        pixel_sensor_config::readScene(mode);
        do_reset();
        words.delete();
        ff_rises = 0;
        wait_rise(name);
        tests++;
        if (words.size() != 8) begin
            fails++;
            $display("FAIL %s word_count: got %0d, expected 8", name, words.size());
        end
        check_frame(name, mode, 0);
        tests++;
        if (ff_rises != 1) begin
            fails++;
            $display("FAIL %s ff_pulses: got %0d, expected 1", name, ff_rises);
        end
    endtask

    task automatic test_ratio();
        clk_half = 125;
        bclk_half = 250;
        test_scene("ratio_swapped", 1);
        clk_half = 250;
        bclk_half = 125;
    endtask

    task automatic test_reset_mid();
        int n1;
        bit seen = 1'b0;
        pixel_sensor_config::readScene(1);
        do_reset();
        words.delete();
        for (int i = 0; i < 4000; i++) begin
            @(posedge buffer_clk);
            if (words.size() >= 5) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL mid_row2_timeout: got %0d words, expected 5", words.size());
        end
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge buffer_clk);
        #1 n1 = words.size();
        repeat (20) @(negedge buffer_clk);
        tests++;
        if (words.size() != n1) begin
            fails++;
            $display("FAIL mid_abort_pulses: got %0d words, expected %0d", words.size(), n1);
        end
        tests++;
        if (frame_finished !== 1'b0) begin
            fails++;
            $display("FAIL mid_abort_ff: got %b, expected 0", frame_finished);
        end
        @(negedge clk);
        reset = 1'b1;
        words.delete();
        wait_rise("mid_recover");
        tests++;
        if (words.size() != 8) begin
            fails++;
            $display("FAIL mid_recover_count: got %0d, expected 8", words.size());
        end
        check_frame("mid_recover", 1, 0);
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        pixel_sensor_config::readScene(1);
        do_reset();
        words.delete();
        falls.delete();
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk);
            if (falls.size() >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL b2b_timeout: got %0d falls, expected 2", falls.size());
        end else begin
            tests++;
            if (falls[0] != 8) begin
                fails++;
                $display("FAIL b2b_fall1: got %0d words, expected 8", falls[0]);
            end
            tests++;
            if (falls[1] != 16) begin
                fails++;
                $display("FAIL b2b_fall2: got %0d words, expected 16", falls[1]);
            end
        end
        check_frame("b2b_frame1", 1, 0);
        check_frame("b2b_frame2", 1, 8);
    endtask

    initial begin
        test_reset();
        test_scene("scene_zero", 0);
        test_scene("scene_ramp", 1);
        test_scene("scene_ones", 2);
        test_ratio();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
